nios_cpu_nios2_qsys_0_ocimem_arbiter: RTL and testbench
=======================================================

// Module: nios_cpu_nios2_qsys_0_ocimem_arbiter
// PURPOSE
//  Sequences and arbitrates access to the on-chip debug (OCI) RAM between two requesters. One is the JTAG debug
//  path: take_action/no_action pulses plus jdo from the sysclk-domain debug logic. The other is the CPU debug Avalon slave.
//  Returns JTAG read data in MonDReg and reports monitor_ready/monitor_error back to the JTAG TCK scan logic.
//  Sits in the clk domain beside the debug-module sysclk block; owns the single OCI RAM port.
// PARAMETERS
//  ADDR_W   8    OCI RAM word-address width (2**ADDR_W x 32-bit words)
//  DATA_W   32   data width; fixed 32, byte enables are DATA_W/8 bits
// PORTS
//  clk                      in   1       system clock
//  reset_n                  in   1       asynchronous, active-low reset
//  jdo                      in   38      JTAG data: [33]=clear error, [34:3]=write data, [17+ADDR_W-1:17]=address
//  take_action_ocimem_a     in   1       pulse: load address from jdo, clear error if jdo[33], then read
//  take_action_ocimem_b     in   1       pulse: write jdo[34:3] at current address, then increment it
//  take_no_action_ocimem_a  in   1       pulse: read at current address, then increment it
//  avs_address              in   ADDR_W  CPU word address
//  avs_read / avs_write     in   1       CPU read/write request, held until waitrequest low
//  avs_writedata            in   32      CPU write data
//  avs_byteenable           in   4       CPU byte enables
//  avs_readdata             out  32      CPU read data, valid when avs_read & ~avs_waitrequest
//  avs_waitrequest          out  1       stall CPU request
//  ram_addr / ram_wdata     out  ADDR_W/32  RAM address / write data
//  ram_byteen               out  4       RAM byte enables (4'hF for JTAG writes)
//  ram_wren / ram_rden      out  1       RAM write / read strobe, single-cycle
//  ram_rdata                in   32      RAM read data, registered, valid 1 cycle after ram_rden
//  MonDReg                  out  32      last JTAG read data
//  monitor_ready            out  1       JTAG operation complete
//  monitor_error            out  1       sticky JTAG overrun flag
// BEHAVIOUR
//  Reset (async):
//   - all regs 0: MonDReg=0, monitor_ready=0, monitor_error=0, jtag address=0
//   - jtag_pend=0, state=IDLE, last_grant=CPU
//   - strobes 0; avs_waitrequest = avs_read|avs_write
//   - A reset mid-access abandons the access; no RAM strobe is issued afterward.
//  JTAG capture (one-deep):
//   - A pulse sets jtag_pend and latches op {RD,WR} and data; it clears monitor_ready next cycle.
//   - If several pulses arrive in one cycle, priority is ocimem_a > ocimem_b > no_action_a.
//     The losers are dropped and monitor_error is set.
//   - A pulse while jtag_pend=1 is dropped and monitor_error is set (overrun); the pending op is unaffected.
//   - monitor_error clears only on ocimem_a with jdo[33]=1. That pulse's own overrun, if any, wins (error stays 1).
//  FSM states:
//   - IDLE: pick a requester; if both request, grant the one != last_grant, else grant whichever requests.
//     Grant-WR: ram_wren=1 this cycle. CPU write: waitrequest=0 this cycle. JTAG write: addr+1, monitor_ready=1 next cycle.
//     Stay in IDLE after a write.
//     Grant-RD: ram_rden=1, go to RD_CPU or RD_JTAG; last_grant updated.
//   - RD_CPU: avs_readdata=ram_rdata, waitrequest=0, go to IDLE.
//   - RD_JTAG: MonDReg<=ram_rdata, monitor_ready<=1, jtag_pend<=0, go to IDLE.
//     Increment address on no_action_a only; ocimem_a keeps its loaded address.
//  Timing and addressing:
//   - Write latency 1 cycle from grant; read latency 2 cycles (grant + data).
//   - Max CPU stall with JTAG contending: 3 cycles.
//   - JTAG address increments modulo 2**ADDR_W (all-ones wraps to 0).
//   - CPU address is unused after grant; the CPU must hold its request per Avalon rules.
// STRUCTURE
//  Package nios_cpu_nios2_qsys_0_ocimem_pkg holds:
//   - state enum {IDLE, RD_CPU, RD_JTAG}
//   - requester enum {CPU, JTAG}
//   - jdo field bit constants (CLR_ERR_BIT=33, WDATA_LSB=3, ADDR_LSB=17)
//  Sub-module nios_cpu_nios2_qsys_0_ocimem_jtag_req: one-deep JTAG pulse capture, pulse priority, overrun/error flag.
// TESTING
//  1. ocimem_a, jdo addr=8'h10, RAM[16]=32'hDEADBEEF -> MonDReg=DEADBEEF, monitor_ready=1 2 cycles after grant, address stays 16.
//  2. ocimem_b, data=32'h12345678, then no_action_a -> write to addr 16, read from addr 17, address ends at 18.
//  3. CPU read and JTAG read pending together in the same cycle after reset:
//     JTAG granted first, then CPU; avs_waitrequest high exactly 3 cycles; avs_readdata correct.
//  4. Second JTAG pulse while one is pending -> monitor_error=1, pending op completes normally.
//     ocimem_a with jdo[33]=1 -> monitor_error=0.
//  5. JTAG address 8'hFF, no_action_a -> read from 255, next access from 0.
//  6. reset_n low during RD_JTAG -> all outputs at reset values; no ram_rden/ram_wren after release until a new request.

Source files
------------

// File: rtl/nios_cpu_nios2_qsys_0_ocimem_pkg.sv
// Shared types and constants for the OCI RAM arbiter.
//   state_t     : arbiter FSM states
//   requester_t : which side was granted last (round-robin memory)
//   jtag_op_t   : kind of the captured JTAG operation
//   jdo field positions for the clear-error bit, write data and address.
package nios_cpu_nios2_qsys_0_ocimem_pkg;

  localparam int JDO_W       = 38;
  localparam int CLR_ERR_BIT = 33;
  localparam int WDATA_LSB   = 3;
  localparam int ADDR_LSB    = 17;

  typedef enum logic [1:0] {IDLE = 2'd0, RD_CPU = 2'd1, RD_JTAG = 2'd2} state_t;
  typedef enum logic {CPU = 1'b0, JTAG = 1'b1} requester_t;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} jtag_op_t;

endpackage

// File: rtl/nios_cpu_nios2_qsys_0_ocimem_jtag_req.sv
// One-deep capture of JTAG ocimem pulses.
//   take_action_ocimem_a / take_action_ocimem_b / take_no_action_ocimem_a : request pulses
//   jdo       : JTAG data (write data, clear-error bit)
//   done      : the arbiter has finished the pending op
//   pend      : an op is captured and waiting/in progress
//   op, wdata : captured op kind and write data
//   inc_addr  : captured op increments the address after its read
//   capture   : a pulse was accepted this cycle
//   load_addr : the accepted pulse was ocimem_a (address comes from jdo)
//   monitor_error : sticky overrun flag
module nios_cpu_nios2_qsys_0_ocimem_jtag_req
  import nios_cpu_nios2_qsys_0_ocimem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              done,
  output logic              pend,
  output jtag_op_t          op,
  output logic [31:0]       wdata,
  output logic              inc_addr,
  output logic              capture,
  output logic              load_addr,
  output logic              monitor_error
);

  logic any_pulse;
  logic multi_pulse;
  logic overrun;
  logic win_b;
  logic win_n;
  logic unused_jdo;

  assign unused_jdo  = ^{jdo[JDO_W-1:WDATA_LSB+32], jdo[WDATA_LSB-1:0]};

  assign any_pulse   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_pulse = (take_action_ocimem_a & take_action_ocimem_b) |
                       (take_action_ocimem_a & take_no_action_ocimem_a) |
                       (take_action_ocimem_b & take_no_action_ocimem_a);
  // Anything arriving while an op is pending, or losing the same-cycle priority, is lost.
  assign overrun     = (any_pulse & pend) | multi_pulse;
  assign capture     = any_pulse & ~pend;
  assign win_b       = ~take_action_ocimem_a & take_action_ocimem_b;
  assign win_n       = ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;
  assign load_addr   = capture & take_action_ocimem_a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend          <= 1'b0;
      op            <= OP_RD;
      wdata         <= '0;
      inc_addr      <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (capture) begin
        pend     <= 1'b1;
        op       <= win_b ? OP_WR : OP_RD;
        wdata    <= jdo[WDATA_LSB +: 32];
        inc_addr <= win_n;
      end else if (done) begin
        pend <= 1'b0;
      end
      // A clearing ocimem_a that itself overruns leaves the flag set.
      if (overrun)
        monitor_error <= 1'b1;
      else if (load_addr && jdo[CLR_ERR_BIT])
        monitor_error <= 1'b0;
    end
  end

endmodule

// File: rtl/nios_cpu_nios2_qsys_0_ocimem_arbiter.sv
// Arbitrates the single OCI RAM port between the JTAG debug path and the
// CPU debug Avalon slave.
//   clk, reset_n           : clock, async active-low reset
//   jdo, take_*            : JTAG op pulses and data
//   avs_*                  : CPU Avalon slave (held request, waitrequest stall)
//   ram_*                  : RAM port; ram_rdata valid one cycle after ram_rden
//   MonDReg, monitor_ready, monitor_error : JTAG results/status
//   dbg_state              : current FSM state for observation
// Handshake: a CPU request is held until avs_waitrequest is low; a write
// completes in the cycle it is granted, a read returns avs_readdata in the
// cycle waitrequest drops (RD_CPU).
module nios_cpu_nios2_qsys_0_ocimem_arbiter
  import nios_cpu_nios2_qsys_0_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_waitrequest,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_byteen,
  output logic                ram_wren,
  output logic                ram_rden,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  output logic [1:0]          dbg_state
);

  state_t             state;
  requester_t         last_grant;
  logic [ADDR_W-1:0]  jtag_addr;
  logic               pend;
  jtag_op_t           op;
  logic [31:0]        jwdata;
  logic               inc_addr;
  logic               capture;
  logic               load_addr;
  logic               cpu_req;
  logic               grant_cpu;
  logic               grant_jtag;
  logic               done;

  nios_cpu_nios2_qsys_0_ocimem_jtag_req u_jtag_req (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .done                    (done),
    .pend                    (pend),
    .op                      (op),
    .wdata                   (jwdata),
    .inc_addr                (inc_addr),
    .capture                 (capture),
    .load_addr               (load_addr),
    .monitor_error           (monitor_error)
  );

  assign cpu_req = avs_read | avs_write;

  // Grants exist only in IDLE and out of reset, so no strobe leaks while reset_n is low.
  // On contention the side that was not granted last wins.
  assign grant_cpu  = reset_n && (state == IDLE) && cpu_req && (!pend || last_grant == JTAG);
  assign grant_jtag = reset_n && (state == IDLE) && pend && (!cpu_req || last_grant == CPU);

  assign ram_addr   = grant_cpu ? avs_address    : jtag_addr;
  assign ram_wdata  = grant_cpu ? avs_writedata  : jwdata;
  assign ram_byteen = grant_cpu ? avs_byteenable : '1;
  assign ram_wren   = (grant_cpu & avs_write) | (grant_jtag & (op == OP_WR));
  assign ram_rden   = (grant_cpu & ~avs_write) | (grant_jtag & (op == OP_RD));

  assign avs_waitrequest = cpu_req & ~(grant_cpu & avs_write) & (state != RD_CPU);
  assign avs_readdata    = (state == RD_CPU) ? ram_rdata : '0;

  assign done      = (grant_jtag & (op == OP_WR)) | (state == RD_JTAG);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_grant    <= CPU;
      jtag_addr     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
    end else begin
      // capture only happens with nothing pending, so it never overlaps a JTAG completion below
      if (capture) begin
        monitor_ready <= 1'b0;
        if (load_addr)
          jtag_addr <= jdo[ADDR_LSB +: ADDR_W];
      end
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            last_grant <= CPU;
            if (!avs_write)
              state <= RD_CPU;
          end else if (grant_jtag) begin
            last_grant <= JTAG;
            if (op == OP_WR) begin
              jtag_addr     <= jtag_addr + 1'b1;
              monitor_ready <= 1'b1;
            end else begin
              state <= RD_JTAG;
            end
          end
        end
        RD_CPU: state <= IDLE;
        RD_JTAG: begin
          MonDReg       <= ram_rdata;
          monitor_ready <= 1'b1;
          if (inc_addr)
            jtag_addr <= jtag_addr + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_cpu_nios2_qsys_0_ocimem_arbiter.sv
module tb_nios_cpu_nios2_qsys_0_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteen;
  logic        ram_wren;
  logic        ram_rden;
  logic [31:0] ram_rdata = '0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem [256];
  int          strobe_cnt = 0;
  logic [7:0]  last_rd_addr = '0;
  logic [7:0]  last_wr_addr = '0;

  nios_cpu_nios2_qsys_0_ocimem_arbiter dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_byteen              (ram_byteen),
    .ram_wren                (ram_wren),
    .ram_rden                (ram_rden),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .dbg_state               (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM model: registered read, byte-enabled write; also records strobes
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]   = 32'h0BADF00D;
    mem[5]   = 32'h55555555;
    mem[16]  = 32'hDEADBEEF;
    mem[17]  = 32'h17171717;
    mem[18]  = 32'h18181818;
    mem[19]  = 32'h19191919;
    mem[20]  = 32'h20202020;
    mem[30]  = 32'hAAAAAAAA;
    mem[255] = 32'hFF00FF00;
  end

  always @(posedge clk) begin
    logic [31:0] m;
    m = {{8{ram_byteen[3]}}, {8{ram_byteen[2]}}, {8{ram_byteen[1]}}, {8{ram_byteen[0]}}};
    if (ram_wren) begin
      mem[ram_addr] <= (mem[ram_addr] & ~m) | (ram_wdata & m);
      last_wr_addr  <= ram_addr;
    end
    if (ram_rden) begin
      ram_rdata    <= mem[ram_addr];
      last_rd_addr <= ram_addr;
    end
    if (ram_rden || ram_wren) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] j);
    @(negedge clk);
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = n;
    jdo = j;
    @(posedge clk);
    #1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic clr);
    logic [37:0] j;
    j = '0;
    j[24:17] = addr;
    j[33] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic wait_ready(input string tag, output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!monitor_ready && n < 20);
    check({tag, "_ready"}, {31'b0, monitor_ready}, 32'd1);
    lat = n;
  endtask

  task automatic check_mon(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(tag, MonDReg, e);
  endtask

  initial begin
    int lat;
    int cnt;
    int base;

    // reset values, CPU read held during reset
    reset_n  = 1'b0;
    avs_read = 1'b1;
    #7;
    check("rst_waitreq", {31'b0, avs_waitrequest}, 32'd1);
    check("rst_rden",    {31'b0, ram_rden}, 32'd0);
    check("rst_wren",    {31'b0, ram_wren}, 32'd0);
    check("rst_mon",     MonDReg, 32'h0);
    check("rst_ready",   {31'b0, monitor_ready}, 32'd0);
    check("rst_error",   {31'b0, monitor_error}, 32'd0);
    avs_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // contention: JTAG pending and CPU read in the same cycle
    exp_q.push_back(32'h55555555);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(8'd5, 1'b0));
    avs_read    = 1'b1;
    avs_address = 8'd20;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      cnt++;
    end
    check("cont_stall", cnt, 32'd3);
    check("cont_rdata", avs_readdata, 32'h20202020);
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    wait_ready("cont", lat);
    check_mon("cont_mon");

    // CPU byte-enabled write, completes in grant cycle
    @(negedge clk);
    avs_write      = 1'b1;
    avs_address    = 8'd30;
    avs_writedata  = 32'h12345678;
    avs_byteenable = 4'b0011;
    #1;
    check("cpuwr_waitreq", {31'b0, avs_waitrequest}, 32'd0);
    check("cpuwr_wren",    {31'b0, ram_wren}, 32'd1);
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    check("cpuwr_mem", mem[30], 32'hAAAA5678);

    // ocimem_a read at 16
    exp_q.push_back(32'hDEADBEEF);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b0));
    wait_ready("t1", lat);
    check("t1_lat", lat, 32'd3);
    check_mon("t1_mon");
    check("t1_rdaddr", {24'b0, last_rd_addr}, 32'd16);

    // ocimem_b write at 16 (address kept), then no_action reads 17 and 18
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h12345678));
    wait_ready("t2w", lat);
    check("t2w_lat", lat, 32'd2);
    check("t2w_mem", mem[16], 32'h12345678);
    check("t2w_addr", {24'b0, last_wr_addr}, 32'd16);
    exp_q.push_back(32'h17171717);
    pulse(1'b0, 1'b0, 1'b1, '0);
    wait_ready("t2r", lat);
    check_mon("t2r_mon");
    exp_q.push_back(32'h18181818);
    pulse(1'b0, 1'b0, 1'b1, '0);
    wait_ready("t2r2", lat);
    check_mon("t2r2_mon");

    // overrun: ocimem_b arrives while the no_action read at 19 is pending
    exp_q.push_back(32'h19191919);
    pulse(1'b0, 1'b0, 1'b1, '0);
    pulse(1'b0, 1'b1, 1'b0, jdo_b(32'hCAFECAFE));
    wait_ready("t4", lat);
    check_mon("t4_mon");
    check("t4_err", {31'b0, monitor_error}, 32'd1);
    check("t4_nowr", mem[20], 32'h20202020);

    // clear error with ocimem_a at 255, then wrap
    exp_q.push_back(32'hFF00FF00);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b1));
    wait_ready("t5a", lat);
    check_mon("t5a_mon");
    check("t5a_err", {31'b0, monitor_error}, 32'd0);
    exp_q.push_back(32'hFF00FF00);
    pulse(1'b0, 1'b0, 1'b1, '0);
    wait_ready("t5b", lat);
    check_mon("t5b_mon");
    check("t5b_rdaddr", {24'b0, last_rd_addr}, 32'd255);
    exp_q.push_back(32'h0BADF00D);
    pulse(1'b0, 1'b0, 1'b1, '0);
    wait_ready("t5c", lat);
    check_mon("t5c_mon");
    check("t5c_rdaddr", {24'b0, last_rd_addr}, 32'd0);

    // simultaneous a+b: a wins, its own overrun beats its clear bit
    exp_q.push_back(32'h12345678);
    pulse(1'b1, 1'b1, 1'b0, jdo_a(8'h10, 1'b1));
    wait_ready("multi", lat);
    check_mon("multi_mon");
    check("multi_err", {31'b0, monitor_error}, 32'd1);
    check("multi_nowr", mem[17], 32'h17171717);

    // reset during RD_JTAG
    pulse(1'b1, 1'b0, 1'b0, jdo_a(8'd17, 1'b0));
    @(negedge clk);
    @(negedge clk);
    check("t6_inrd", {30'b0, dbg_state}, 32'd2);
    reset_n = 1'b0;
    #1;
    check("t6_mon",   MonDReg, 32'h0);
    check("t6_ready", {31'b0, monitor_ready}, 32'd0);
    check("t6_err",   {31'b0, monitor_error}, 32'd0);
    check("t6_rden",  {31'b0, ram_rden}, 32'd0);
    check("t6_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    base = strobe_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("t6_nostrobe", strobe_cnt - base, 32'd0);
    exp_q.push_back(32'h0BADF00D);
    pulse(1'b0, 1'b0, 1'b1, '0);
    wait_ready("t6n", lat);
    check_mon("t6n_mon");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
